// File: rtl/div_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ITER = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_datapath.sv
// Datapath for the repeated-subtraction divider: running remainder R, divisor D,
// quotient count Q and the divide-by-zero flag, steered by the controller.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             ld_fast,
    input  logic             sub,
    input  logic             set_dz,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ge,
    output logic             dz,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dbz_q, dbz_d;

    assign ge = (r_q >= d_q);
    assign dz = (d_q == '0);

    always_comb begin
        r_d   = r_q;
        d_d   = d_q;
        q_d   = q_q;
        dbz_d = dbz_q;
        if (ld) begin
            dbz_d = 1'b0;
            d_d   = divisor;
            // Unit divisor shortcut: the whole dividend is the quotient.
            if (ld_fast) begin
                q_d = dividend;
                r_d = '0;
            end else begin
                q_d = '0;
                r_d = dividend;
            end
        end else if (set_dz) begin
            dbz_d = 1'b1;
            q_d   = '1;
        end else if (sub) begin
            r_d = r_q - d_q;
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            d_q   <= '0;
            q_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            d_q   <= d_d;
            q_q   <= q_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/repeated_sub_divider.sv
// Unsigned divider by repeated subtraction: controller FSM around div_datapath.
// Optional DIV_FAST_PATH_EN completes divisor==1 directly on accept.
module repeated_sub_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_t state_q, state_d;

    logic ld;
    logic ld_fast;
    logic sub;
    logic set_dz;
    logic ge;
    logic dz;
    logic fast_ok;

`ifdef DIV_FAST_PATH_EN
    assign fast_ok = (divisor == WIDTH'(1));
`else
    assign fast_ok = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_fast = 1'b0;
        sub     = 1'b0;
        set_dz  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ld      = 1'b1;
                    ld_fast = fast_ok;
                    state_d = fast_ok ? DONE : ITER;
                end
            end
            ITER: begin
                // Zero divisor must win before the compare, which would loop forever.
                if (dz) begin
                    set_dz  = 1'b1;
                    state_d = DONE;
                end else if (ge) begin
                    sub = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q == ITER) || (state_q == DONE);
    assign done = (state_q == DONE);

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .ld          (ld),
        .ld_fast     (ld_fast),
        .sub         (sub),
        .set_dz      (set_dz),
        .dividend    (dividend),
        .divisor     (divisor),
        .ge          (ge),
        .dz          (dz),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Self-checking bench for repeated_sub_divider: directed cases plus random operands
// against an arithmetic reference model.
module tb_repeated_sub_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic [7:0] quotient;
    logic [7:0] remainder;

    int n_cmp;
    int n_mis;

    repeated_sub_divider #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return 1;
`ifdef DIV_FAST_PATH_EN
        if (b == 8'd1) return 0;
`endif
        return int'(a) / int'(b) + 1;
    endfunction

    // Accept a/b at edge 0, optionally pulse start with ga/gb before edge glitch_edge,
    // then check latency, results, the one-cycle done pulse and result hold.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int glitch_edge, input logic [7:0] ga, input logic [7:0] gb);
        int         edges;
        int         lat;
        logic [7:0] eq;
        logic [7:0] er;
        logic       edz;
        edz = (b == 8'd0);
        eq  = edz ? 8'hFF : 8'(int'(a) / int'(b));
        er  = edz ? a : 8'(int'(a) % int'(b));
        lat = exp_latency(a, b);

        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        check_eq({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 300) begin
            if (edges + 1 == glitch_edge) begin
                start    = 1'b1;
                dividend = ga;
                divisor  = gb;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
        end
        check_eq({tag, " done_seen"}, 32'(done), 32'd1);
        check_eq({tag, " latency"}, 32'(edges), 32'(lat));
        check_eq({tag, " quotient"}, 32'(quotient), 32'(eq));
        check_eq({tag, " remainder"}, 32'(remainder), 32'(er));
        check_eq({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        // Start during DONE must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check_eq({tag, " idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_eq({tag, " hold_q"}, 32'(quotient), 32'(eq));
        check_eq({tag, " hold_r"}, 32'(remainder), 32'(er));
        check_eq({tag, " hold_dz"}, 32'(div_by_zero), 32'(edz));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         lat;
        int         ge_edge;
        n_cmp    = 0;
        n_mis    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_q", 32'(quotient), 32'd0);
        check_eq("reset_r", 32'(remainder), 32'd0);
        check_eq("reset_dz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        do_op("t1_81_10", 8'h81, 8'h10, -1, 8'h00, 8'h00);
        do_op("t2_lt", 8'h05, 8'h07, -1, 8'h00, 8'h00);
        do_op("t3_dz", 8'h65, 8'h00, -1, 8'h00, 8'h00);
        do_op("t4_ff_1", 8'hFF, 8'h01, -1, 8'h00, 8'h00);
        do_op("t5_ignore", 8'h90, 8'h09, 3, 8'h23, 8'h02);
        do_op("b_zero", 8'h00, 8'h37, -1, 8'h00, 8'h00);
        do_op("b_eq", 8'hA5, 8'hA5, -1, 8'h00, 8'h00);
        do_op("b_zero_zero", 8'h00, 8'h00, -1, 8'h00, 8'h00);

        // Reset mid-operation.
        @(negedge clk);
        dividend = 8'h40;
        divisor  = 8'h04;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("t6_rst_q", 32'(quotient), 32'd0);
        check_eq("t6_rst_r", 32'(remainder), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_done", 32'(done), 32'd0);
        check_eq("t6_rst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("t6_after", 8'h23, 8'h05, -1, 8'h00, 8'h00);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 8'($urandom_range(0, 3));
                1: rb = 8'($urandom_range(1, 16));
                default: rb = 8'($urandom);
            endcase
            lat = exp_latency(ra, rb);
            ge_edge = (lat >= 1 && ($urandom_range(0, 1) == 1)) ? $urandom_range(1, lat) : -1;
            do_op("rand", ra, rb, ge_edge, 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
